// File: rtl/ofdm_pkg.sv
// ofdm_pkg: OFDM symbol layout (64 bins, 48 data, 4 pilots, 12 nulls), pilot LFSR constants,
// bin classification and scheduler state encoding.
package ofdm_pkg;
    localparam int NFFT = 64;
    localparam int N_DATA = 48;
    localparam int NULL_LO = 27;
    localparam int NULL_HI = 37;
    localparam int PILOT_BIN0 = 7;
    localparam int PILOT_BIN1 = 21;
    localparam int PILOT_BIN2 = 43;
    localparam int PILOT_BIN3 = 57;
    localparam logic [6:0] LFSR_SEED = 7'h7F;
    localparam int LFSR_TAP_HI = 6;
    localparam int LFSR_TAP_LO = 3;

    typedef enum logic [1:0] {BIN_NULL, BIN_PILOT, BIN_DATA} bin_t;
    typedef enum logic [1:0] {FILL, EMIT, GAP} state_t;

    function automatic bin_t bin_type(input logic [5:0] idx);
        if (idx == 6'd0 || (idx >= 6'(NULL_LO) && idx <= 6'(NULL_HI)))
            return BIN_NULL;
        if (idx == 6'(PILOT_BIN0) || idx == 6'(PILOT_BIN1) ||
            idx == 6'(PILOT_BIN2) || idx == 6'(PILOT_BIN3))
            return BIN_PILOT;
        return BIN_DATA;
    endfunction

    // Base pilot signs are +,+,+,- ; only the last pilot starts negative
    function automatic logic pilot_base_neg(input logic [5:0] idx);
        return idx == 6'(PILOT_BIN3);
    endfunction
endpackage

// File: rtl/ofdm_pilot_lfsr.sv
// ofdm_pilot_lfsr: x^7+x^4+1 pilot polarity generator; polarity is the feedback bit of the
// current state, so the all-ones seed yields +,+,+,+,-,-,-,+ ...
module ofdm_pilot_lfsr
    import ofdm_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic step,
    input  logic seed,
    output logic polarity
);
    logic [6:0] state;

    assign polarity = state[LFSR_TAP_HI] ^ state[LFSR_TAP_LO];

    always_ff @(posedge clk or negedge reset)
        if (!reset)
            state <= LFSR_SEED;
        else if (seed)
            state <= LFSR_SEED;
        else if (step)
            state <= {state[5:0], polarity};
endmodule

// File: rtl/ofdm_symbol_scheduler.sv
// ofdm_symbol_scheduler: buffers 48 mapped samples and streams one 64-bin symbol per burst to IFFT64.
// Define OFDM_PILOT_POLARITY_EN to scramble pilot polarity per symbol with a 7-bit LFSR.
module ofdm_symbol_scheduler
    import ofdm_pkg::*;
#(
    parameter int WIDTH      = 16,
    parameter int PILOT_AMP  = 16384,
    parameter int GAP_CYCLES = 64
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [WIDTH-1:0] in_re,
    input  logic signed [WIDTH-1:0] in_im,
    input  logic                    flush,
    output logic                    di_en,
    output logic signed [WIDTH-1:0] di_re,
    output logic signed [WIDTH-1:0] di_im,
    output logic [7:0]              sym_count,
    output logic                    busy
);
    localparam int GW = $clog2(GAP_CYCLES) + 1;
    localparam logic signed [WIDTH-1:0] AMP = WIDTH'(PILOT_AMP);

    state_t state;
    logic [5:0] fill_cnt, bin_cnt, rd_ptr, nxt_bin;
    logic [GW-1:0] gap_cnt;
    logic [2*WIDTH-1:0] buffer [N_DATA];
    logic [2*WIDTH-1:0] nxt_word;
    logic signed [WIDTH-1:0] pilot_re;
    logic polarity, wr, last_in, last_bin;

    // in_ready is registered high only in FILL, so it doubles as the state qualifier
    assign wr = in_valid & in_ready & ~flush;
    assign last_in = wr && fill_cnt == 6'(N_DATA - 1);
    assign last_bin = bin_cnt == 6'(NFFT - 1);
    assign nxt_bin = bin_cnt + 6'd1;
    assign pilot_re = (pilot_base_neg(nxt_bin) ^ polarity) ? -AMP : AMP;

    always_comb
        nxt_word = bin_type(nxt_bin) == BIN_DATA  ? buffer[rd_ptr] :
                   bin_type(nxt_bin) == BIN_PILOT ? {pilot_re, {WIDTH{1'b0}}} : '0;

`ifdef OFDM_PILOT_POLARITY_EN
    ofdm_pilot_lfsr u_lfsr (
        .clk     (clk),
        .reset   (reset),
        .step    (state == EMIT && last_bin),
        .seed    (1'b0),
        .polarity(polarity)
    );
`else
    assign polarity = 1'b0;
`endif

    always_ff @(posedge clk)
        if (wr)
            buffer[fill_cnt] <= {in_re, in_im};

    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            state <= FILL;
            fill_cnt <= '0;
            bin_cnt <= '0;
            rd_ptr <= '0;
            gap_cnt <= '0;
            in_ready <= 1'b0;
            busy <= 1'b0;
            di_en <= 1'b0;
            di_re <= '0;
            di_im <= '0;
            sym_count <= '0;
        end else begin
            case (state)
                FILL: begin
                    in_ready <= ~last_in;
                    fill_cnt <= (flush || last_in) ? '0 : fill_cnt + 6'(wr);
                    if (last_in) begin
                        state <= EMIT;
                        busy <= 1'b1;
                        di_en <= 1'b1;
                        bin_cnt <= '0;
                        rd_ptr <= '0;
                        di_re <= '0;
                        di_im <= '0;
                    end
                end
                // Bin 0 was loaded on entry; each edge presents the following bin
                EMIT: begin
                    bin_cnt <= nxt_bin;
                    di_en <= ~last_bin;
                    {di_re, di_im} <= nxt_word;
                    if (bin_type(nxt_bin) == BIN_DATA)
                        rd_ptr <= rd_ptr + 6'd1;
                    if (last_bin) begin
                        state <= GAP;
                        gap_cnt <= '0;
                        sym_count <= sym_count + 8'd1;
                    end
                end
                GAP: begin
                    if (gap_cnt == GW'(GAP_CYCLES - 1)) begin
                        state <= FILL;
                        in_ready <= 1'b1;
                        busy <= 1'b0;
                    end else
                        gap_cnt <= gap_cnt + GW'(1);
                end
                default: state <= FILL;
            endcase
        end
endmodule

// File: tb/tb_ofdm_symbol_scheduler.sv
// tb_ofdm_symbol_scheduler: randomized bench with a symbol-level reference model of the scheduler.
// Honours OFDM_PILOT_POLARITY_EN in its pilot expectations.
module tb_ofdm_symbol_scheduler;
    localparam int GAP = 64;

    logic clk = 0, reset = 1, in_valid = 0, flush = 0;
    logic signed [15:0] in_re = 0, in_im = 0;
    logic in_ready, di_en, busy;
    logic signed [15:0] di_re, di_im;
    logic [7:0] sym_count;
    int total = 0, bad = 0;

    logic [31:0] acc[$], exp_q[$], burst_q[$], cur[$];
    int len_q[$], low_q[$];
    int low_run = 0, model_sym = 0;

    always #5 clk = ~clk;

    ofdm_symbol_scheduler #(.WIDTH(16), .PILOT_AMP(16384), .GAP_CYCLES(GAP)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_re(in_re), .in_im(in_im), .flush(flush), .di_en(di_en),
        .di_re(di_re), .di_im(di_im), .sym_count(sym_count), .busy(busy)
    );

    // Collects each di_en burst and each in_ready-low run length
    always @(negedge clk) begin
        if (!reset) begin
            cur.delete();
            low_run = 0;
        end else begin
            if (di_en)
                cur.push_back({di_re, di_im});
            else if (cur.size() > 0) begin
                len_q.push_back(cur.size());
                foreach (cur[i]) burst_q.push_back(cur[i]);
                cur.delete();
            end
            if (!in_ready)
                low_run++;
            else if (low_run > 0) begin
                low_q.push_back(low_run);
                low_run = 0;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1, "watchdog");
    end

    // Pilot polarity of symbol n since reset: feedback of x^7+x^4+1 from the all-ones seed
    function automatic bit pol_neg(int n);
`ifdef OFDM_PILOT_POLARITY_EN
        int r = 127;
        bit b = 0;
        for (int i = 0; i <= n; i++) begin
            b = bit'(((r >> 6) ^ (r >> 3)) & 1);
            r = ((r << 1) | int'(b)) & 127;
        end
        return b;
`else
        return 1'b0 & (n < 0);
`endif
    endfunction

    task automatic model_accept(logic [31:0] w);
        acc.push_back(w);
        if (acc.size() == 48) begin
            int d = 0;
            for (int k = 0; k < 64; k++) begin
                if (k == 0 || (k >= 27 && k <= 37))
                    exp_q.push_back(32'h0);
                else if (k == 7 || k == 21 || k == 43 || k == 57)
                    exp_q.push_back({((k == 57) ^ pol_neg(model_sym)) ? -16'sd16384 : 16'sd16384, 16'h0});
                else begin
                    exp_q.push_back(acc[d]);
                    d++;
                end
            end
            acc.delete();
            model_sym++;
        end
    endtask

    task automatic clear_sb();
        acc.delete(); exp_q.delete(); burst_q.delete(); len_q.delete(); low_q.delete();
    endtask

    task automatic push(logic [15:0] re, logic [15:0] im);
        int n = 0;
        in_valid = 1; in_re = re; in_im = im;
        while (!in_ready && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            total++; bad++;
            $display("FAIL push_timeout in_ready=%b want=1", in_ready);
        end else
            model_accept({re, im});
        @(negedge clk);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (!in_ready && n < 1000) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (!in_ready) begin bad++; $display("FAIL idle_timeout in_ready=%b want=1", in_ready); end
    endtask

    task automatic wait_bursts(int num);
        int n = 0;
        while (len_q.size() < num && n < 2000) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (len_q.size() < num) begin
            bad++;
            $display("FAIL burst_timeout got=%0d want=%0d", len_q.size(), num);
        end
    endtask

    task automatic check_bursts();
        while (len_q.size() > 0) begin
            int len = len_q.pop_front();
            total++;
            if (len != 64) begin bad++; $display("FAIL burst_len got=%0d want=64", len); end
            for (int i = 0; i < len; i++) begin
                logic [31:0] got, want;
                got = burst_q.pop_front();
                want = 32'hxxxxxxxx;
                if (exp_q.size() > 0) want = exp_q.pop_front();
                total++;
                if (got !== want) begin bad++; $display("FAIL bin%0d got=%h want=%h", i, got, want); end
            end
        end
        total++;
        if (exp_q.size() != 0 || acc.size() != 0) begin
            bad++;
            $display("FAIL leftover exp=%0d acc=%0d want=0,0", exp_q.size(), acc.size());
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 0; in_valid = 0; flush = 0;
        repeat (3) @(negedge clk);
        reset = 1;
        @(negedge clk);
        clear_sb();
        model_sym = 0;
    endtask

    task automatic test_reset();
        #2 reset = 0;
        in_valid = 1; in_re = 5; in_im = 5;
        repeat (5) begin
            @(negedge clk);
            total++;
            if (in_ready !== 0 || di_en !== 0 || sym_count !== 0 || busy !== 0 || di_re !== 0 || di_im !== 0) begin
                bad++;
                $display("FAIL reset_hold ready=%b en=%b cnt=%0d busy=%b re=%0d im=%0d want 0s",
                         in_ready, di_en, sym_count, busy, di_re, di_im);
            end
        end
        in_valid = 0;
        reset = 1;
        #1 total++;
        if (in_ready !== 0) begin bad++; $display("FAIL release_pre in_ready=%b want=0", in_ready); end
        @(negedge clk);
        total++;
        if (in_ready !== 1) begin bad++; $display("FAIL release_ready in_ready=%b want=1", in_ready); end
        clear_sb();
        model_sym = 0;
    endtask

    task automatic test_basic_symbol();
        logic [31:0] cap [64];
        for (int j = 0; j < 48; j++) push(16'(j), 16'(-j));
        in_valid = 0;
        for (int i = 0; i < 64; i++) begin
            cap[i] = {di_re, di_im};
            total++;
            if (di_en !== 1 || cap[i] !== exp_q[i]) begin
                bad++;
                $display("FAIL basic_bin%0d en=%b got=%h want=%h", i, di_en, cap[i], exp_q[i]);
            end
            @(negedge clk);
        end
        total++;
        if (cap[2] !== {16'sd1, -16'sd1} || cap[63] !== {16'sd47, -16'sd47} || cap[1] !== 32'h0) begin
            bad++;
            $display("FAIL basic_data b1=%h b2=%h b63=%h want 0/0001ffff/002fffd1", cap[1], cap[2], cap[63]);
        end
        total++;
        if (cap[0] !== 32'h0 || cap[30] !== 32'h0) begin
            bad++; $display("FAIL basic_null b0=%h b30=%h want=0", cap[0], cap[30]);
        end
        total++;
        if (cap[7] !== {16'sd16384, 16'h0} || cap[57] !== {-16'sd16384, 16'h0}) begin
            bad++; $display("FAIL basic_pilot b7=%h b57=%h want=40000000/c0000000", cap[7], cap[57]);
        end
        total++;
        if (di_en !== 0 || di_re !== 0 || di_im !== 0 || busy !== 1 || in_ready !== 0) begin
            bad++;
            $display("FAIL basic_gap en=%b re=%0d im=%0d busy=%b ready=%b want 0,0,0,1,0", di_en, di_re, di_im, busy, in_ready);
        end
        total++;
        if (sym_count !== 8'd1) begin bad++; $display("FAIL basic_count got=%0d want=1", sym_count); end
        exp_q.delete();
    endtask

    task automatic test_back_to_back();
        wait_idle();
        clear_sb();
        for (int j = 0; j < 144; j++) push(16'($urandom), 16'($urandom));
        in_valid = 0;
        wait_bursts(3);
        wait_idle();
        total++;
        if (low_q.size() != 3) begin bad++; $display("FAIL b2b_runs got=%0d want=3", low_q.size()); end
        foreach (low_q[i]) begin
            total++;
            if (low_q[i] != 64 + GAP) begin bad++; $display("FAIL b2b_low%0d got=%0d want=%0d", i, low_q[i], 64 + GAP); end
        end
        check_bursts();
        total++;
        if (sym_count !== 8'd4) begin bad++; $display("FAIL b2b_count got=%0d want=4", sym_count); end
    endtask

    task automatic test_flush();
        wait_idle();
        clear_sb();
        for (int j = 0; j < 20; j++) push(16'($urandom), 16'($urandom));
        flush = 1; in_valid = 1; in_re = 16'sd999; in_im = 16'sd999;
        @(negedge clk);
        flush = 0; in_valid = 0;
        acc.delete();
        for (int j = 0; j < 48; j++) push(16'(100 + j), 16'($urandom));
        in_valid = 0;
        wait_bursts(1);
        total++;
        if (burst_q.size() < 2 || burst_q[1][31:16] !== 16'd100) begin
            bad++; $display("FAIL flush_bin1 got=%h want re=0064", burst_q.size() > 1 ? burst_q[1] : 32'hx);
        end
        check_bursts();
    endtask

    task automatic test_reset_mid();
        wait_idle();
        clear_sb();
        for (int j = 0; j < 48; j++) push(16'($urandom), 16'($urandom));
        in_valid = 0;
        repeat (30) @(negedge clk);
        reset = 0;
        #1 total++;
        if (di_en !== 0 || di_re !== 0 || busy !== 0 || in_ready !== 0 || sym_count !== 0) begin
            bad++;
            $display("FAIL midreset en=%b re=%0d busy=%b ready=%b cnt=%0d want 0s", di_en, di_re, busy, in_ready, sym_count);
        end
        @(negedge clk);
        reset = 1;
        @(negedge clk);
        total++;
        if (in_ready !== 1 || busy !== 0 || sym_count !== 0) begin
            bad++; $display("FAIL midreset_release ready=%b busy=%b cnt=%0d want 1,0,0", in_ready, busy, sym_count);
        end
        clear_sb();
        model_sym = 0;
        for (int j = 0; j < 48; j++) push(16'($urandom), 16'($urandom));
        in_valid = 0;
        wait_bursts(1);
        check_bursts();
    endtask

    task automatic test_polarity();
        logic [15:0] w7, w57;
        do_reset();
        for (int j = 0; j < 240; j++) begin
            if ($urandom_range(0, 3) == 0) begin
                in_valid = 0;
                @(negedge clk);
            end
            push(16'($urandom), 16'($urandom));
        end
        in_valid = 0;
        wait_bursts(5);
        for (int s = 0; s < 5; s++) begin
`ifdef OFDM_PILOT_POLARITY_EN
            w7 = (s == 4) ? 16'hC000 : 16'h4000;
`else
            w7 = 16'h4000;
`endif
            total++;
            if (burst_q.size() < 320 || burst_q[s * 64 + 7][31:16] !== w7) begin
                bad++; $display("FAIL pol_bin7 sym%0d want=%h", s, w7);
            end
        end
`ifdef OFDM_PILOT_POLARITY_EN
        w57 = 16'h4000;
`else
        w57 = 16'hC000;
`endif
        total++;
        if (burst_q.size() < 320 || burst_q[4 * 64 + 57][31:16] !== w57) begin
            bad++; $display("FAIL pol_bin57 sym4 want=%h", w57);
        end
        check_bursts();
        total++;
        if (sym_count !== 8'd5) begin bad++; $display("FAIL pol_count got=%0d want=5", sym_count); end
    endtask

    initial begin
        test_reset();
        test_basic_symbol();
        test_back_to_back();
        test_flush();
        test_reset_mid();
        test_polarity();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
